fp_op_sequencer: RTL and testbench

//  Sequences the multi-cycle FPALU inside the single-cycle RV32IMF datapath.
//  It latches the operation and operands of a decoded FP instruction and holds

---
 rtl/fp_op_sequencer.sv | 123 ++++++++++++
 tb/tb_fp_op_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp_op_sequencer.sv
// rtl/fp_op_sequencer.sv - holds FP operands stable at the multi-cycle FPALU and stalls the datapath until capture
module fp_op_sequencer #(
    parameter logic [4:0]  OPC_FADD  = 5'd0,
    parameter logic [4:0]  OPC_FSUB  = 5'd1,
    parameter logic [4:0]  OPC_FMUL  = 5'd2,
    parameter logic [4:0]  OPC_FDIV  = 5'd3,
    parameter logic [4:0]  OPC_FSQRT = 5'd4,
    parameter int unsigned LAT_ADD   = 7,
    parameter int unsigned LAT_MUL   = 5,
    parameter int unsigned LAT_DIV   = 6,
    parameter int unsigned LAT_SQRT  = 16,
    parameter int unsigned LAT_DFLT  = 1
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iStart,
    input  logic [4:0]  iOp,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    input  logic        iAbort,
    output logic [4:0]  oFPControl,
    output logic [31:0] oFPA,
    output logic [31:0] oFPB,
    input  logic [31:0] iFPResult,
    output logic [31:0] oResult,
    output logic        oValid,
    output logic        oStall,
    output logic        oBusy
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    // A zero latency would never reach the cnt==1 capture point, so clamp into 1..31.
    function automatic logic [4:0] sat_lat(input int unsigned v);
        if (v == 0)       return 5'd1;
        else if (v > 31)  return 5'd31;
        else              return 5'(v);
    endfunction

    localparam logic [4:0] L_ADD  = sat_lat(LAT_ADD);
    localparam logic [4:0] L_MUL  = sat_lat(LAT_MUL);
    localparam logic [4:0] L_DIV  = sat_lat(LAT_DIV);
    localparam logic [4:0] L_SQRT = sat_lat(LAT_SQRT);
    localparam logic [4:0] L_DFLT = sat_lat(LAT_DFLT);

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [4:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_result;
    logic [4:0]  w_lat;
    logic        w_issue;
    logic        w_capture;

    always_comb begin
        w_lat = L_DFLT;
        if (iOp == OPC_FADD || iOp == OPC_FSUB) w_lat = L_ADD;
        else if (iOp == OPC_FMUL)               w_lat = L_MUL;
        else if (iOp == OPC_FDIV)               w_lat = L_DIV;
        else if (iOp == OPC_FSQRT)              w_lat = L_SQRT;
    end

    always_comb begin
        w_next    = r_state;
        oStall    = 1'b0;
        w_issue   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                oStall = iStart;
                if (iStart && !iAbort) begin
                    w_issue = 1'b1;
                    w_next  = S_BUSY;
                end
            end
            S_BUSY: begin
                oStall = 1'b1;
                if (r_cnt == 5'd1) begin
                    w_capture = !iAbort;
                    w_next    = S_DONE;
                end
            end
            // iStart in DONE still belongs to the completing instruction.
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (iAbort) w_next = S_IDLE;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_op     <= 5'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_result <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_issue) begin
                r_op  <= iOp;
                r_a   <= iA;
                r_b   <= iB;
                r_cnt <= w_lat;
            end else if (iAbort) begin
                r_cnt <= 5'd0;
            end else if (r_state == S_BUSY && r_cnt != 5'd0) begin
                r_cnt <= r_cnt - 5'd1;
            end
            if (w_capture) r_result <= iFPResult;
        end
    end

    assign oFPControl = r_op;
    assign oFPA       = r_a;
    assign oFPB       = r_b;
    assign oResult    = r_result;
    assign oValid     = (r_state == S_DONE) && !iAbort;
    assign oBusy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_fp_op_sequencer.sv
// tb/tb_fp_op_sequencer.sv - directed bench for fp_op_sequencer with a latency-aware FPALU model
module tb_fp_op_sequencer;

    logic        iCLK = 1'b0;
    logic        iRST_n;
    logic        iStart;
    logic [4:0]  iOp;
    logic [31:0] iA;
    logic [31:0] iB;
    logic        iAbort;
    logic [4:0]  oFPControl;
    logic [31:0] oFPA;
    logic [31:0] oFPB;
    logic [31:0] iFPResult;
    logic [31:0] oResult;
    logic        oValid;
    logic        oStall;
    logic        oBusy;

    int checks = 0;
    int errors = 0;
    int r_age  = 0;

    fp_op_sequencer dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
        .iAbort(iAbort), .oFPControl(oFPControl), .oFPA(oFPA), .oFPB(oFPB),
        .iFPResult(iFPResult), .oResult(oResult), .oValid(oValid), .oStall(oStall), .oBusy(oBusy)
    );

    always #5 iCLK = ~iCLK;

    function automatic int tb_lat(input logic [4:0] op);
        case (op)
            5'd0, 5'd1: return 7;
            5'd2:       return 5;
            5'd3:       return 6;
            5'd4:       return 16;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [31:0] tb_fpu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 5'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == 5'd4 && a == 32'h41800000)                      return 32'h40800000;
        if (op == 5'd2 && a == 32'h40400000 && b == 32'h40000000) return 32'h40C00000;
        return a ^ b ^ {27'd0, op};
    endfunction

    // The model only shows a correct result once its inputs have been held for the op's full latency.
    always @(posedge iCLK) begin
        if (oStall && !oBusy) r_age <= 1;
        else if (oBusy)       r_age <= r_age + 1;
        else                  r_age <= 0;
    end

    always_comb begin
        iFPResult = 32'hBAD0BAD0;
        if (r_age == tb_lat(oFPControl)) iFPResult = tb_fpu(oFPControl, oFPA, oFPB);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] res);
        iStart = 1'b1; iOp = op; iA = a; iB = b;
        #1;
        chk("issue_stall", 32'(oStall), 32'd1);
        chk("issue_busy", 32'(oBusy), 32'd0);
        for (int c = 1; c <= lat + 1; c++) begin
            tick();
            iA = $urandom; iB = $urandom; iOp = 5'($urandom_range(0, 31));
            #1;
            chk("stall", 32'(oStall), 32'(c <= lat));
            chk("valid", 32'(oValid), 32'(c == lat + 1));
            if (c <= lat) begin
                chk("held_a", oFPA, a);
                chk("held_b", oFPB, b);
                chk("held_op", 32'(oFPControl), 32'(op));
            end else begin
                chk("result", oResult, res);
            end
        end
        tick();
        iStart = 1'b0; iA = 32'd0; iB = 32'd0; iOp = 5'd0;
        #1;
        chk("after_busy", 32'(oBusy), 32'd0);
        chk("after_valid", 32'(oValid), 32'd0);
    endtask

    initial begin
        iRST_n = 1'b0; iStart = 1'b0; iOp = 5'd0; iA = 32'd0; iB = 32'd0; iAbort = 1'b0;
        repeat (2) tick();
        chk("rst_ctl", 32'(oFPControl), 32'd0);
        chk("rst_a", oFPA, 32'd0);
        chk("rst_b", oFPB, 32'd0);
        chk("rst_res", oResult, 32'd0);
        chk("rst_valid", 32'(oValid), 32'd0);
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_stall0", 32'(oStall), 32'd0);
        iStart = 1'b1;
        #1;
        chk("rst_stall1", 32'(oStall), 32'd1);
        iStart = 1'b0;
        tick();
        iRST_n = 1'b1;
        tick();

        // FADD, FSQRT, then unknown op followed by FMUL issued in cycle 3
        run_op(5'd0, 32'h3F800000, 32'h40000000, 7, 32'h40400000);
        run_op(5'd4, 32'h41800000, 32'h00000000, 16, 32'h40800000);
        tick();
        run_op(5'd9, 32'h00000001, 32'h00000002, 1, 32'h0000000A);
        run_op(5'd2, 32'h40400000, 32'h40000000, 5, 32'h40C00000);

        // abort in BUSY cycle 2 of an FADD
        tick();
        iStart = 1'b1; iOp = 5'd0; iA = 32'h3F800000; iB = 32'h40000000;
        tick();
        tick();
        iAbort = 1'b1;
        #1;
        chk("abort_stall", 32'(oStall), 32'd1);
        tick();
        iAbort = 1'b0; iStart = 1'b0;
        #1;
        chk("abort_idle", 32'(oBusy), 32'd0);
        for (int c = 0; c < 10; c++) begin
            chk("abort_novalid", 32'(oValid), 32'd0);
            tick();
        end
        chk("abort_res", oResult, 32'h40C00000);

        // async reset in BUSY cycle 3 of an FDIV
        iStart = 1'b1; iOp = 5'd3; iA = 32'h12345678; iB = 32'h9ABCDEF0;
        repeat (3) tick();
        chk("fdiv_busy", 32'(oBusy), 32'd1);
        #1;
        iRST_n = 1'b0; iStart = 1'b0;
        #1;
        chk("arst_ctl", 32'(oFPControl), 32'd0);
        chk("arst_a", oFPA, 32'd0);
        chk("arst_b", oFPB, 32'd0);
        chk("arst_res", oResult, 32'd0);
        chk("arst_valid", 32'(oValid), 32'd0);
        chk("arst_busy", 32'(oBusy), 32'd0);
        chk("arst_stall", 32'(oStall), 32'd0);
        tick();
        iRST_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("post_rst_valid", 32'(oValid), 32'd0);
            chk("post_rst_busy", 32'(oBusy), 32'd0);
        end

        // iStart held for 20 cycles: issue 0, DONE 6, re-issue 7, DONE 13, re-issue 14
        iStart = 1'b1; iOp = 5'd2; iA = 32'h40400000; iB = 32'h40000000;
        #1;
        for (int c = 0; c < 20; c++) begin
            chk("hold_valid", 32'(oValid), 32'(c == 6 || c == 13));
            chk("hold_busy", 32'(oBusy), 32'(c != 0 && c != 7 && c != 14));
            chk("hold_stall", 32'(oStall), 32'(c != 6 && c != 13));
            if (c == 6) chk("hold_res", oResult, 32'h40C00000);
            tick();
        end
        iStart = 1'b0;
        #1;
        chk("hold_last_valid", 32'(oValid), 32'd1);
        tick();
        chk("hold_end_busy", 32'(oBusy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
